// File: rtl/fetch_request.sv
// fetch_request: frontend fetch issuer sitting behind next_pc.
// Issues one instruction-cache request at a time. It hands the returned word
// to the instruction queue, or asks next_pc to replay it when the queue is
// full. After any pulse it sends back to next_pc (if_ready / replay / flush),
// it waits one extra cycle so that next_pc's two-stage registered npc update
// has landed before a new address is sampled.
module fetch_request #(
    // Core configuration handle; this block has no configuration-dependent
    // behaviour, so the value is not consulted.
    parameter int unsigned CVA6Cfg     = 0,
    parameter int unsigned VLEN        = 64,
    parameter int unsigned FETCH_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [VLEN-1:0]        next_addr_i,
    // instruction cache request side
    output logic                   icache_req_o,
    output logic [VLEN-1:0]        icache_vaddr_o,
    input  logic                   icache_ready_i,
    output logic                   icache_kill_s1_o,
    output logic                   icache_kill_s2_o,
    // instruction cache response side
    input  logic                   icache_valid_i,
    input  logic [FETCH_WIDTH-1:0] icache_data_i,
    input  logic                   icache_ex_i,
    // instruction queue
    input  logic                   iq_ready_i,
    output logic                   fetch_valid_o,
    output logic [FETCH_WIDTH-1:0] fetch_data_o,
    output logic [VLEN-1:0]        fetch_addr_o,
    output logic                   fetch_ex_o,
    // feedback to next_pc
    output logic                   if_ready_o,
    output logic                   replay_o,
    output logic [VLEN-1:0]        replay_addr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [VLEN-1:0] req_addr_q, req_addr_d;
    // High for the cycle right after a pulse to next_pc; next_pc's npc is not
    // yet valid then, so IDLE must not sample next_addr_i.
    logic            settle_q, settle_d;

    // The address register only changes on capture in IDLE, so it is stable
    // for the whole REQ phase and also names the outstanding word in WAIT.
    assign icache_vaddr_o = req_addr_q;

    // Next-state and output decode; flush wins over every other event.
    always_comb begin
        state_d          = state_q;
        req_addr_d       = req_addr_q;
        icache_req_o     = 1'b0;
        icache_kill_s1_o = 1'b0;
        icache_kill_s2_o = 1'b0;
        fetch_valid_o    = 1'b0;
        fetch_data_o     = '0;
        fetch_addr_o     = '0;
        fetch_ex_o       = 1'b0;
        if_ready_o       = 1'b0;
        replay_o         = 1'b0;
        replay_addr_o    = '0;

        case (state_q)
            IDLE: begin
                // Capture only once next_pc has settled, and never while a
                // flush is redirecting it.
                if (!settle_q && !flush_i) begin
                    req_addr_d = {next_addr_i[VLEN-1:2], 2'b00};
                    state_d    = REQ;
                end
            end

            REQ: begin
                icache_req_o = 1'b1;
                if (flush_i) begin
                    // Kill in the handshake cycle; an accept here must not
                    // advance next_pc.
                    icache_kill_s1_o = 1'b1;
                    state_d          = IDLE;
                end else if (icache_ready_i) begin
                    if_ready_o = 1'b1;
                    state_d    = WAIT;
                end
            end

            WAIT: begin
                if (flush_i) begin
                    // Outstanding request is killed; a response landing in the
                    // same cycle is discarded.
                    icache_kill_s2_o = 1'b1;
                    state_d          = IDLE;
                end else if (icache_valid_i) begin
                    if (iq_ready_i) begin
                        fetch_valid_o = 1'b1;
                        fetch_data_o  = icache_data_i;
                        fetch_addr_o  = req_addr_q;
                        fetch_ex_o    = icache_ex_i;
                    end else begin
                        // Queue full: drop the word and have next_pc rewind.
                        replay_o      = 1'b1;
                        replay_addr_o = req_addr_q;
                    end
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        settle_d = if_ready_o | replay_o | flush_i;
    end

    // State, captured address and settle flag; reset parks in IDLE unsettled
    // so the first capture happens one cycle after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            settle_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            settle_q   <= settle_d;
        end
    end

endmodule

// File: tb/tb_fetch_request.sv
// Directed bench for fetch_request. Inputs change just after the falling
// edge; outputs are sampled 1 time unit later, well away from the rising edge.
module tb_fetch_request;

    localparam int unsigned VLEN = 32;
    localparam int unsigned FW   = 32;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic [VLEN-1:0] next_addr_i;
    logic            icache_req_o;
    logic [VLEN-1:0] icache_vaddr_o;
    logic            icache_ready_i;
    logic            icache_kill_s1_o;
    logic            icache_kill_s2_o;
    logic            icache_valid_i;
    logic [FW-1:0]   icache_data_i;
    logic            icache_ex_i;
    logic            iq_ready_i;
    logic            fetch_valid_o;
    logic [FW-1:0]   fetch_data_o;
    logic [VLEN-1:0] fetch_addr_o;
    logic            fetch_ex_o;
    logic            if_ready_o;
    logic            replay_o;
    logic [VLEN-1:0] replay_addr_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    fetch_request #(
        .CVA6Cfg    (0),
        .VLEN       (VLEN),
        .FETCH_WIDTH(FW)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .next_addr_i     (next_addr_i),
        .icache_req_o    (icache_req_o),
        .icache_vaddr_o  (icache_vaddr_o),
        .icache_ready_i  (icache_ready_i),
        .icache_kill_s1_o(icache_kill_s1_o),
        .icache_kill_s2_o(icache_kill_s2_o),
        .icache_valid_i  (icache_valid_i),
        .icache_data_i   (icache_data_i),
        .icache_ex_i     (icache_ex_i),
        .iq_ready_i      (iq_ready_i),
        .fetch_valid_o   (fetch_valid_o),
        .fetch_data_o    (fetch_data_o),
        .fetch_addr_o    (fetch_addr_o),
        .fetch_ex_o      (fetch_ex_o),
        .if_ready_o      (if_ready_o),
        .replay_o        (replay_o),
        .replay_addr_o   (replay_addr_o)
    );

    // Move to the next cycle: inputs may be driven right after this returns.
    task automatic tick();
        @(negedge clk_i);
    endtask

    // Reset, release at a falling edge (cycle 0), then advance to cycle 2
    // where the first request is expected. Returns 1 time unit into cycle 2.
    task automatic reset_to_req(input logic [VLEN-1:0] addr, input logic rdy);
        rst_ni         = 1'b0;
        flush_i        = 1'b0;
        icache_valid_i = 1'b0;
        icache_data_i  = '0;
        icache_ex_i    = 1'b0;
        iq_ready_i     = 1'b1;
        icache_ready_i = rdy;
        next_addr_i    = addr;
        tick(); tick();
        rst_ni = 1'b1;       // cycle 0
        tick();              // cycle 1
        tick(); #1;          // cycle 2
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; flush_i = 1'b0; icache_valid_i = 1'b1; iq_ready_i = 1'b1;
        icache_ready_i = 1'b1; icache_data_i = 32'h1234_5678; icache_ex_i = 1'b1;
        next_addr_i = 32'h8000_0000;
        tick(); tick(); #1;
        n_chk++;
        if ({icache_req_o, icache_kill_s1_o, icache_kill_s2_o, fetch_valid_o, fetch_ex_o,
             if_ready_o, replay_o} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 0", {icache_req_o, icache_kill_s1_o,
                icache_kill_s2_o, fetch_valid_o, fetch_ex_o, if_ready_o, replay_o});
        end
        n_chk++;
        if ({icache_vaddr_o, fetch_addr_o, fetch_data_o, replay_addr_o} !== 128'b0) begin
            n_fail++; $display("FAIL reset_data vaddr=%h faddr=%h fdata=%h raddr=%h",
                icache_vaddr_o, fetch_addr_o, fetch_data_o, replay_addr_o);
        end
    endtask

    task automatic test_boot_sequence();
        reset_to_req(32'h8000_0000, 1'b1);
        n_chk++;
        if ({icache_req_o, if_ready_o, icache_vaddr_o} !== {2'b11, 32'h8000_0000}) begin
            n_fail++; $display("FAIL boot_req c2 req=%b ifr=%b vaddr=%h want 1 1 80000000",
                icache_req_o, if_ready_o, icache_vaddr_o);
        end
        tick();              // cycle 3: response, next_pc has moved on
        next_addr_i = 32'h8000_0004; icache_valid_i = 1'b1; icache_data_i = 32'hdead_beef; #1;
        n_chk++;
        if ({fetch_valid_o, fetch_addr_o, fetch_data_o, fetch_ex_o, if_ready_o, icache_req_o}
            !== {1'b1, 32'h8000_0000, 32'hdead_beef, 3'b000}) begin
            n_fail++; $display("FAIL boot_resp fv=%b addr=%h data=%h ex=%b ifr=%b req=%b",
                fetch_valid_o, fetch_addr_o, fetch_data_o, fetch_ex_o, if_ready_o, icache_req_o);
        end
        tick(); icache_valid_i = 1'b0; #1;  // cycle 4: settling
        n_chk++;
        if ({icache_req_o, fetch_valid_o} !== 2'b00) begin
            n_fail++; $display("FAIL boot_idle c4 req=%b fv=%b want 0 0", icache_req_o, fetch_valid_o);
        end
        tick(); #1;                          // cycle 5: second request
        n_chk++;
        if ({icache_req_o, if_ready_o, icache_vaddr_o} !== {2'b11, 32'h8000_0004}) begin
            n_fail++; $display("FAIL boot_req2 c5 req=%b ifr=%b vaddr=%h want 1 1 80000004",
                icache_req_o, if_ready_o, icache_vaddr_o);
        end
        // Reset with the request outstanding: response must be ignored.
        tick(); rst_ni = 1'b0; icache_valid_i = 1'b1; #1;
        n_chk++;
        if ({fetch_valid_o, replay_o, icache_req_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid fv=%b rp=%b req=%b want 0", fetch_valid_o,
                replay_o, icache_req_o);
        end
    endtask

    task automatic test_stall();
        reset_to_req(32'h8000_0008, 1'b0);
        next_addr_i = 32'h1234_5678;  // must not disturb the held request
        for (int c = 2; c <= 4; c++) begin
            n_chk++;
            if ({icache_req_o, if_ready_o, icache_vaddr_o} !== {2'b10, 32'h8000_0008}) begin
                n_fail++; $display("FAIL stall_hold c%0d req=%b ifr=%b vaddr=%h want 1 0 80000008",
                    c, icache_req_o, if_ready_o, icache_vaddr_o);
            end
            tick(); #1;
        end
        icache_ready_i = 1'b1; #1;    // cycle 5: accepted
        n_chk++;
        if ({icache_req_o, if_ready_o, icache_vaddr_o} !== {2'b11, 32'h8000_0008}) begin
            n_fail++; $display("FAIL stall_accept req=%b ifr=%b vaddr=%h want 1 1 80000008",
                icache_req_o, if_ready_o, icache_vaddr_o);
        end
        tick(); icache_ready_i = 1'b0; #1;
        n_chk++;
        if ({icache_req_o, if_ready_o} !== 2'b00) begin
            n_fail++; $display("FAIL stall_after req=%b ifr=%b want 0 0", icache_req_o, if_ready_o);
        end
    endtask

    task automatic test_replay();
        reset_to_req(32'h8000_0010, 1'b1);
        tick();              // cycle 3: response with queue full
        next_addr_i = 32'h8000_0014; icache_valid_i = 1'b1; iq_ready_i = 1'b0;
        icache_data_i = 32'hcafe_0001; #1;
        n_chk++;
        if ({replay_o, replay_addr_o, fetch_valid_o, if_ready_o} !== {1'b1, 32'h8000_0010, 2'b00}) begin
            n_fail++; $display("FAIL replay_pulse rp=%b raddr=%h fv=%b ifr=%b want 1 80000010 0 0",
                replay_o, replay_addr_o, fetch_valid_o, if_ready_o);
        end
        tick();              // cycle 4: next_pc rewinds
        icache_valid_i = 1'b0; iq_ready_i = 1'b1; next_addr_i = 32'h8000_0010; #1;
        n_chk++;
        if ({icache_req_o, replay_o} !== 2'b00) begin
            n_fail++; $display("FAIL replay_settle req=%b rp=%b want 0 0", icache_req_o, replay_o);
        end
        tick(); #1;          // cycle 5: capture
        n_chk++;
        if (icache_req_o !== 1'b0) begin
            n_fail++; $display("FAIL replay_capture req=%b want 0", icache_req_o);
        end
        tick(); #1;          // cycle 6: re-request
        n_chk++;
        if ({icache_req_o, icache_vaddr_o} !== {1'b1, 32'h8000_0010}) begin
            n_fail++; $display("FAIL replay_rereq req=%b vaddr=%h want 1 80000010",
                icache_req_o, icache_vaddr_o);
        end
    endtask

    task automatic test_flush_wait();
        reset_to_req(32'h8000_0020, 1'b1);
        tick();              // cycle 3: flush together with a response
        next_addr_i = 32'h8000_0024; flush_i = 1'b1; icache_valid_i = 1'b1; #1;
        n_chk++;
        if ({icache_kill_s2_o, icache_kill_s1_o, fetch_valid_o, replay_o} !== 4'b1000) begin
            n_fail++; $display("FAIL flush_wait k2=%b k1=%b fv=%b rp=%b want 1 0 0 0",
                icache_kill_s2_o, icache_kill_s1_o, fetch_valid_o, replay_o);
        end
        tick();              // cycle 4: redirect from commit
        flush_i = 1'b0; icache_valid_i = 1'b0; next_addr_i = 32'h8000_0100; #1;
        n_chk++;
        if ({icache_req_o, icache_kill_s2_o} !== 2'b00) begin
            n_fail++; $display("FAIL flush_wait_idle req=%b k2=%b want 0 0", icache_req_o,
                icache_kill_s2_o);
        end
        tick(); tick(); #1;  // cycle 6
        n_chk++;
        if ({icache_req_o, icache_vaddr_o} !== {1'b1, 32'h8000_0100}) begin
            n_fail++; $display("FAIL flush_wait_rereq req=%b vaddr=%h want 1 80000100",
                icache_req_o, icache_vaddr_o);
        end
    endtask

    task automatic test_flush_req();
        reset_to_req(32'h8000_0030, 1'b1);
        flush_i = 1'b1; #1;  // cycle 2: flush during handshake
        n_chk++;
        if ({icache_kill_s1_o, if_ready_o, icache_kill_s2_o} !== 3'b100) begin
            n_fail++; $display("FAIL flush_req k1=%b ifr=%b k2=%b want 1 0 0",
                icache_kill_s1_o, if_ready_o, icache_kill_s2_o);
        end
        tick(); flush_i = 1'b0; next_addr_i = 32'h8000_0200; #1;  // cycle 3
        n_chk++;
        if ({icache_req_o, icache_kill_s1_o} !== 2'b00) begin
            n_fail++; $display("FAIL flush_req_idle req=%b k1=%b want 0 0", icache_req_o,
                icache_kill_s1_o);
        end
        tick(); tick(); #1;  // cycle 5
        n_chk++;
        if ({icache_req_o, if_ready_o, icache_vaddr_o} !== {2'b11, 32'h8000_0200}) begin
            n_fail++; $display("FAIL flush_req_rereq req=%b ifr=%b vaddr=%h want 1 1 80000200",
                icache_req_o, if_ready_o, icache_vaddr_o);
        end
    endtask

    task automatic test_exception();
        // Unaligned next_pc value must be word-aligned on the request.
        reset_to_req(32'h8000_0042, 1'b1);
        n_chk++;
        if (icache_vaddr_o !== 32'h8000_0040) begin
            n_fail++; $display("FAIL align vaddr=%h want 80000040", icache_vaddr_o);
        end
        tick();
        icache_valid_i = 1'b1; icache_ex_i = 1'b1; icache_data_i = 32'h0bad_f00d; #1;
        n_chk++;
        if ({fetch_valid_o, fetch_ex_o, fetch_addr_o, fetch_data_o}
            !== {2'b11, 32'h8000_0040, 32'h0bad_f00d}) begin
            n_fail++; $display("FAIL exception fv=%b ex=%b addr=%h data=%h want 1 1 80000040 0badf00d",
                fetch_valid_o, fetch_ex_o, fetch_addr_o, fetch_data_o);
        end
        tick(); icache_valid_i = 1'b0; icache_ex_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_boot_sequence();
        test_stall();
        test_replay();
        test_flush_wait();
        test_flush_req();
        test_exception();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_request.md
# fetch_request

Frontend fetch issuer paired with `next_pc`. It takes `next_addr_i` (`next_pc`'s `next_addr_o`) and issues one instruction-cache request at a time. It forwards the returned fetch word to the instruction queue and drives `next_pc`'s `if_ready_i`, `replay_i` and `replay_addr_i` back. It owns the one-outstanding-request policy and waits out `next_pc`'s two-stage registered update before sampling a new address.

## Interface
- `CVA6Cfg`, default `config_pkg::cva6_cfg_empty`: core configuration.
- `VLEN`, default `riscv::VLEN`: virtual address width.
- `FETCH_WIDTH`, default `ariane_pkg::FETCH_WIDTH` (32): fetch data width.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `flush_i`, in, 1: frontend flush; kills the in-flight request.
- `next_addr_i`, in, VLEN: address from `next_pc`.
- `icache_req_o`, out, 1: request valid.
- `icache_vaddr_o`, out, VLEN: request address, word-aligned (`[1:0]=0`).
- `icache_ready_i`, in, 1: cache accepts the request.
- `icache_kill_s1_o`, out, 1: kill the request in the handshake cycle.
- `icache_kill_s2_o`, out, 1: kill the outstanding request.
- `icache_valid_i`, in, 1: response valid.
- `icache_data_i`, in, FETCH_WIDTH: response data.
- `icache_ex_i`, in, 1: response carries a fetch exception.
- `iq_ready_i`, in, 1: instruction queue can accept a word.
- `fetch_valid_o`, out, 1: word delivered to the queue.
- `fetch_data_o`, out, FETCH_WIDTH: delivered data.
- `fetch_addr_o`, out, VLEN: address of the delivered word.
- `fetch_ex_o`, out, 1: delivered word faulted.
- `if_ready_o`, out, 1: to `next_pc` `if_ready_i`; the request was accepted.
- `replay_o`, out, 1: to `next_pc` `replay_i`.
- `replay_addr_o`, out, VLEN: to `next_pc` `replay_addr_i`.

## Operation
- State machine with states IDLE, REQ and WAIT. Registers: `state_q`, `req_addr_q`, and a 1-bit `settle_q`.
- `settle_q` exists because `next_pc` registers `if_ready`, `replay` and the flush/commit controls, and then registers `npc`. A new address therefore appears 2 cycles after a pulse.
  - Any pulse of `if_ready_o`, `replay_o` or `flush_i` loads `settle_q` to 1.
  - Otherwise `settle_q` clears to 0.
- IDLE:
  - If `settle_q==0` and `flush_i==0`: capture `{next_addr_i[VLEN-1:2],2'b0}` into `req_addr_q`, then go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - Drives `icache_req_o=1` and `icache_vaddr_o=req_addr_q`.
  - When `icache_ready_i` is high: `if_ready_o=1` combinationally in that cycle, then go to WAIT.
  - The address is held stable until accepted.
- WAIT: on `icache_valid_i`:
  - If `iq_ready_i`: `fetch_valid_o=1`; `fetch_data_o=icache_data_i`; `fetch_addr_o=req_addr_q`; `fetch_ex_o=icache_ex_i`.
  - If not `iq_ready_i`: the word is dropped, and `replay_o=1` with `replay_addr_o=req_addr_q`.
  - Either way, go to IDLE.
- Flush takes priority in every state:
  - REQ: `icache_kill_s1_o=1`. If the handshake completes in the same cycle, `if_ready_o` is still suppressed.
  - WAIT: `icache_kill_s2_o=1`, and any same-cycle response is suppressed (no `fetch_valid_o`, no `replay_o`).
  - Next state is IDLE with `settle_q=1`.
- At most one request is outstanding. REQ is never entered from WAIT directly.
- `replay_o` and `if_ready_o` are never high in the same cycle. By construction they come from different states.
- `fetch_valid_o`, `replay_o` and `if_ready_o` are combinational from state and inputs. All other state is registered.

## Timing
- Reset values:
  - `state_q=IDLE`, `settle_q=1`, `req_addr_q=0`.
  - All outputs 0.
- After reset release (cycle 0 = first active cycle): `settle_q=0` in cycle 1. The address is captured at the end of cycle 1 and `icache_req_o=1` in cycle 2. `next_pc` has loaded the boot address by cycle 1.
- Handshake in cycle t:
  - `if_ready_o=1` in cycle t only.
  - The earliest response is t+1.
  - `settle_q=1` in t+1, so the capture is no earlier than t+2, when `next_pc`'s new `npc` is visible. The earliest next request is t+3.
- Replay in cycle r: `replay_addr_o` is valid in r only; the re-request is issued no earlier than r+2.
- Flush in cycle f: the capture is no earlier than f+2.
- Response in the same cycle as flush: the response is discarded.
- Reset mid-transaction: the block returns to IDLE immediately and the outstanding response is ignored. The cache is reset by the same `rst_ni`.

## Test plan
- Reset with boot address 0x8000_0000, `icache_ready_i=1`, response 1 cycle later, `iq_ready_i=1`:
  - `icache_req_o` rises in cycle 2 with vaddr 0x8000_0000, and `if_ready_o` pulses.
  - `fetch_valid_o` fires with addr 0x8000_0000.
  - The next request is 0x8000_0004 in cycle 5.
- `icache_ready_i` held low for 3 cycles: `icache_vaddr_o` stays constant, and `if_ready_o` fires only in the accept cycle.
- Response arrives with `iq_ready_i=0` at addr 0x8000_0010:
  - `replay_o=1` and `replay_addr_o=0x8000_0010`; no `fetch_valid_o`.
  - The next request is 0x8000_0010.
- `flush_i` during WAIT together with `icache_valid_i`:
  - `icache_kill_s2_o=1`, and neither `fetch_valid_o` nor `replay_o` fires.
  - The next request uses the address presented 2 cycles later (e.g. 0x8000_0100 from commit).
- `flush_i` in a REQ cycle with `icache_ready_i=1`: `icache_kill_s1_o=1` and `if_ready_o=0`.
- Response with `icache_ex_i=1`: `fetch_ex_o=1` together with `fetch_valid_o`, carrying the correct `fetch_addr_o`.
